// File: rtl/irq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : irq_pkg
//  Description : Shared definitions for the four-channel interrupt front end
//                and the downstream 4-to-2 priority encoder stage.
//  Revision    : 1.0  initial release
// ============================================================================
package irq_pkg;

    localparam int N_CH = 4;
    localparam int ID_W = 2;

    // Presentation FSM states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        GAP     = 2'd2
    } irq_state_e;

    // Highest set bit wins; channel 3 outranks channel 0. Returns 0 for an
    // all-zero vector, so callers must qualify with a reduction-OR.
    function automatic logic [ID_W-1:0] prio_enc(input logic [N_CH-1:0] vec);
        logic [ID_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (vec[i]) begin
                idx = ID_W'(i);
            end
        end
        return idx;
    endfunction

endpackage : irq_pkg
`default_nettype wire

// File: rtl/req_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : req_sync_edge
//  Description : One request channel: multi-stage synchroniser, history flop
//                and a rising-edge pulse taken from the synchronised value.
//  Revision    : 1.0  initial release
// ============================================================================
module req_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_req,
    output logic o_edge
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   hist_q;
    logic                   hist_d;

    // Shift the raw request into the synchroniser; history follows its last stage
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], i_req};
        hist_d = sync_q[SYNC_STAGES-1];
    end

    // Synchroniser and history registers; reset low so a line that is already
    // high at reset release still produces one edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    // The history flop keeps running regardless of enable, so edges are
    // always measured against the true previous sample
    assign o_edge = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule : req_sync_edge
`default_nettype wire

// File: rtl/irq_pending_ctrl4.sv
`default_nettype none
// ============================================================================
//  Module      : irq_pending_ctrl4
//  Description : Four-channel interrupt front end. Edge-detects synchronised
//                requests into sticky pending bits, tracks per-channel
//                overflow, and presents the highest-priority unmasked
//                pending channel with a valid/ack handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module irq_pending_ctrl4
    import irq_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [3:0]      req,
    input  logic [3:0]      mask,
    input  logic            irq_ack,
    input  logic            ovf_clr,
    output logic            irq_valid,
    output logic [1:0]      irq_id,
    output logic [3:0]      pending,
    output logic [3:0]      ovf
);

    // ------------------------------------------------------------------------
    // Per-channel synchroniser and edge detector
    // ------------------------------------------------------------------------
    logic [N_CH-1:0] w_edge;

    generate
        for (genvar g = 0; g < N_CH; g++) begin : g_ch
            req_sync_edge #(
                .SYNC_STAGES (SYNC_STAGES)
            ) u_req_sync_edge (
                .clk    (clk),
                .rst_n  (rst_n),
                .i_req  (req[g]),
                .o_edge (w_edge[g])
            );
        end
    endgenerate

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    irq_state_e      state_q;
    irq_state_e      state_d;
    logic            irq_valid_q;
    logic            irq_valid_d;
    logic [ID_W-1:0] irq_id_q;
    logic [ID_W-1:0] irq_id_d;
    logic [N_CH-1:0] pending_q;
    logic [N_CH-1:0] pending_d;
    logic [N_CH-1:0] ovf_q;
    logic [N_CH-1:0] ovf_d;

    logic [N_CH-1:0] w_avail;
    logic [N_CH-1:0] w_set;
    logic [N_CH-1:0] w_clr;
    logic [N_CH-1:0] w_ovf_set;
    logic            w_ack_take;

    // Channels eligible for presentation
    assign w_avail = pending_q & ~mask;

    // Presentation FSM: priority is only evaluated in IDLE, so a later
    // higher-priority arrival never pre-empts the index being presented
    always_comb begin
        state_d     = state_q;
        irq_valid_d = 1'b0;
        irq_id_d    = irq_id_q;
        w_ack_take  = 1'b0;

        if (!en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|w_avail) begin
                        state_d     = PRESENT;
                        irq_valid_d = 1'b1;
                        irq_id_d    = prio_enc(w_avail);
                    end
                end
                PRESENT: begin
                    // The consumer acked while valid was high, so the
                    // handshake completes even if mask rises in that cycle
                    if (irq_ack) begin
                        w_ack_take = 1'b1;
                        state_d    = GAP;
                    end else if (mask[irq_id_q]) begin
                        state_d = IDLE;
                    end else begin
                        irq_valid_d = 1'b1;
                    end
                end
                GAP: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Pending and overflow update: a new edge beats a same-cycle ack clear,
    // and an overflow set beats a same-cycle ovf_clr
    always_comb begin
        w_clr     = N_CH'(w_ack_take) << irq_id_q;
        w_set     = w_edge & {N_CH{en}};
        w_ovf_set = w_set & pending_q & ~w_clr;
        pending_d = w_set | (pending_q & ~w_clr);
        ovf_d     = w_ovf_set | (ovf_q & ~{N_CH{ovf_clr}});
    end

    // All state and outputs registered with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            irq_valid_q <= 1'b0;
            irq_id_q    <= '0;
            pending_q   <= '0;
            ovf_q       <= '0;
        end else begin
            state_q     <= state_d;
            irq_valid_q <= irq_valid_d;
            irq_id_q    <= irq_id_d;
            pending_q   <= pending_d;
            ovf_q       <= ovf_d;
        end
    end

    assign irq_valid = irq_valid_q;
    assign irq_id    = irq_id_q;
    assign pending   = pending_q;
    assign ovf       = ovf_q;

endmodule : irq_pending_ctrl4
`default_nettype wire

// File: tb/tb_irq_pending_ctrl4.sv
`default_nettype none
// ============================================================================
//  Module      : tb_irq_pending_ctrl4
//  Description : Directed bench for irq_pending_ctrl4 with a presentation
//                scoreboard: expected channel indices are queued as stimulus
//                is issued and checked when irq_valid rises.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_irq_pending_ctrl4;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [3:0] req;
    logic [3:0] mask;
    logic       irq_ack;
    logic       ovf_clr;
    logic       irq_valid;
    logic [1:0] irq_id;
    logic [3:0] pending;
    logic [3:0] ovf;

    int         n_vec;
    int         n_err;
    logic [1:0] exp_q[$];
    logic       mon_prev;
    logic [1:0] mon_exp;

    irq_pending_ctrl4 #(
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req       (req),
        .mask      (mask),
        .irq_ack   (irq_ack),
        .ovf_clr   (ovf_clr),
        .irq_valid (irq_valid),
        .irq_id    (irq_id),
        .pending   (pending),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One-cycle request pulse, called on a falling edge
    task automatic pulse(input logic [3:0] r);
        req = r;
        @(negedge clk);
        req = 4'b0000;
    endtask

    // Bounded wait for a presentation
    task automatic wait_valid(input string name);
        int i;
        i = 0;
        while (!irq_valid && i < 30) begin
            @(negedge clk);
            i++;
        end
        check(name, 32'(irq_valid), 32'd1);
    endtask

    // Ack the presented index and check the result one edge later
    task automatic ack_once(input logic [3:0] pend_after);
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        check("ack_valid_drop", 32'(irq_valid), 32'd0);
        check("ack_pending", 32'(pending), 32'(pend_after));
    endtask

    // Scoreboard monitor: every rising irq_valid must match the queue head
    initial begin
        mon_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (irq_valid === 1'b1 && mon_prev !== 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_present: got id %0d expected no presentation", irq_id);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("present_id", 32'(irq_id), 32'(mon_exp));
                    check("present_pending_bit", 32'(pending[irq_id]), 32'd1);
                end
            end
            mon_prev = irq_valid;
        end
    end

    initial begin
        logic saw;
        n_vec   = 0;
        n_err   = 0;
        rst_n   = 1'b1;
        en      = 1'b1;
        req     = 4'b0000;
        mask    = 4'b0000;
        irq_ack = 1'b0;
        ovf_clr = 1'b0;
        #2 rst_n = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(irq_valid), 32'd0);
        check("rst_id", 32'(irq_id), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single edge on channel 2 with exact latency
        exp_q.push_back(2'd2);
        pulse(4'b0100);
        @(negedge clk);
        check("pend_early", 32'(pending), 32'h0);
        @(negedge clk);
        check("pend_set", 32'(pending), 32'h4);
        check("valid_early", 32'(irq_valid), 32'd0);
        @(negedge clk);
        check("valid_rise", 32'(irq_valid), 32'd1);
        check("id_ch2", 32'(irq_id), 32'd2);
        ack_once(4'b0000);
        @(negedge clk);
        check("post_ack_gap", 32'(irq_valid), 32'd0);
        repeat (2) @(negedge clk);

        // Priority order 3, 1, 0
        exp_q.push_back(2'd3);
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd0);
        pulse(4'b1011);
        wait_valid("prio_wait3");
        ack_once(4'b0011);
        @(negedge clk);
        check("prio_gap1", 32'(irq_valid), 32'd0);
        wait_valid("prio_wait1");
        ack_once(4'b0001);
        @(negedge clk);
        check("prio_gap2", 32'(irq_valid), 32'd0);
        wait_valid("prio_wait0");
        ack_once(4'b0000);
        repeat (3) @(negedge clk);

        // Mask holds back a pending channel
        mask = 4'b1000;
        pulse(4'b1000);
        saw = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (irq_valid) saw = 1'b1;
        end
        check("mask_no_valid", 32'(saw), 32'd0);
        check("mask_pending_held", 32'(pending), 32'h8);
        exp_q.push_back(2'd3);
        mask = 4'b0000;
        wait_valid("unmask_wait");
        mask = 4'b1000;
        @(negedge clk);
        check("mask_drop_valid", 32'(irq_valid), 32'd0);
        check("mask_drop_pending", 32'(pending), 32'h8);
        exp_q.push_back(2'd3);
        mask = 4'b0000;
        wait_valid("remask_wait");
        ack_once(4'b0000);
        repeat (3) @(negedge clk);

        // Overflow on channel 1 (masked so it is not consumed)
        mask = 4'b0010;
        pulse(4'b0010);
        repeat (2) @(negedge clk);
        pulse(4'b0010);
        repeat (5) @(negedge clk);
        check("ovf_set", 32'(ovf), 32'h2);
        check("ovf_pending", 32'(pending), 32'h2);
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        @(negedge clk);
        check("ack_outside_present", 32'(pending), 32'h2);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check("ovf_cleared", 32'(ovf), 32'h0);

        // Ack and new edge on the acked channel in the same cycle
        exp_q.push_back(2'd1);
        mask = 4'b0000;
        wait_valid("ackedge_wait");
        req = 4'b0010;
        @(negedge clk);
        req = 4'b0000;
        @(negedge clk);
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        check("ackedge_valid", 32'(irq_valid), 32'd0);
        check("ackedge_pending", 32'(pending), 32'h2);
        check("ackedge_ovf", 32'(ovf), 32'h0);
        exp_q.push_back(2'd1);
        wait_valid("ackedge_represent");
        ack_once(4'b0000);
        repeat (3) @(negedge clk);

        // Edge while disabled is discarded, none appears on re-enable
        en = 1'b0;
        pulse(4'b0001);
        repeat (5) @(negedge clk);
        en = 1'b1;
        repeat (5) @(negedge clk);
        check("en_off_pending", 32'(pending), 32'h0);
        check("en_off_valid", 32'(irq_valid), 32'd0);

        // Dropping en during PRESENT
        exp_q.push_back(2'd0);
        pulse(4'b0001);
        wait_valid("en_wait");
        en = 1'b0;
        @(negedge clk);
        check("en_drop_valid", 32'(irq_valid), 32'd0);
        check("en_drop_pending", 32'(pending), 32'h1);
        exp_q.push_back(2'd0);
        en = 1'b1;
        wait_valid("en_rewait");
        ack_once(4'b0000);
        repeat (3) @(negedge clk);

        // Asynchronous reset while presenting, with ovf set
        exp_q.push_back(2'd2);
        pulse(4'b0100);
        wait_valid("rst_mid_wait");
        pulse(4'b0100);
        repeat (4) @(negedge clk);
        check("rst_mid_ovf_before", 32'(ovf), 32'h4);
        check("rst_mid_valid_before", 32'(irq_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 32'(irq_valid), 32'd0);
        check("rst_mid_id", 32'(irq_id), 32'd0);
        check("rst_mid_pending", 32'(pending), 32'h0);
        check("rst_mid_ovf", 32'(ovf), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_irq_pending_ctrl4
`default_nettype wire
